// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman / Gotoh affine-gap processing element:
// default widths, traceback codes, saturation rails and the PE state encoding.
package sw_pkg;

    localparam int SW_DEF = 12;
    localparam int CW_DEF = 2;

    localparam logic [1:0] TB_ZERO = 2'b00;
    localparam logic [1:0] TB_DIAG = 2'b01;
    localparam logic [1:0] TB_UP   = 2'b10;
    localparam logic [1:0] TB_LEFT = 2'b11;

    localparam logic signed [SW_DEF-1:0] NEG_DEF = {1'b1, {(SW_DEF-1){1'b0}}};
    localparam logic signed [SW_DEF-1:0] POS_DEF = {1'b0, {(SW_DEF-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCORE = 2'd1,
        ST_DONE  = 2'd2
    } sw_state_e;

endpackage

// File: rtl/sw_sat_addsub.sv
// Signed add/subtract clipped to the SW-bit two's-complement range; sat_o flags a clip.
module sw_sat_addsub
    import sw_pkg::*;
#(
    parameter int SW = SW_DEF
) (
    input  logic signed [SW-1:0] a_i,
    input  logic signed [SW-1:0] b_i,
    input  logic                 sub_i,
    output logic signed [SW-1:0] y_o,
    output logic                 sat_o
);

    localparam logic signed [SW-1:0] NEG = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [SW-1:0] POS = {1'b0, {(SW-1){1'b1}}};

    logic signed [SW:0] a_x;
    logic signed [SW:0] b_x;
    logic signed [SW:0] r_x;

    assign a_x = {a_i[SW-1], a_i};
    assign b_x = {b_i[SW-1], b_i};
    assign r_x = sub_i ? (a_x - b_x) : (a_x + b_x);

    // One guard bit is enough: the two top bits disagree exactly on overflow.
    always_comb begin
        sat_o = (r_x[SW] != r_x[SW-1]);
        y_o   = r_x[SW-1:0];
        if (sat_o) begin
            y_o = r_x[SW] ? NEG : POS;
        end
    end

endmodule

// File: rtl/sw_pe_gotoh.sv
// One systolic processing element of a Gotoh (affine gap) Smith-Waterman/Needleman-Wunsch
// array: scores one database character per beat against its preloaded query character.
module sw_pe_gotoh
    import sw_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_local,
    input  logic                 i_first,
    input  logic [CW-1:0]        i_preload,
    input  logic signed [SW-1:0] i_match,
    input  logic signed [SW-1:0] i_mismatch,
    input  logic [SW-1:0]        i_gopen,
    input  logic [SW-1:0]        i_gext,
    input  logic [CW-1:0]        i_data,
    input  logic                 i_vld,
    input  logic signed [SW-1:0] i_left_h,
    input  logic signed [SW-1:0] i_left_e,
    input  logic signed [SW-1:0] i_high,
    output logic                 o_rst,
    output logic [CW-1:0]        o_data,
    output logic                 o_vld,
    output logic signed [SW-1:0] o_right_h,
    output logic signed [SW-1:0] o_right_e,
    output logic signed [SW-1:0] o_high,
    output logic [1:0]           o_tb,
    output logic                 o_sat,
    output logic                 o_err
);

    localparam logic signed [SW-1:0] NEG = {1'b1, {(SW-1){1'b0}}};

    // Operator slots: 0 Lh-gopen, 1 Le-gext, 2 Hup-gopen, 3 Fup-gext, 4 diag+s, 5 bnd-gext.
    // During reset slots 2 and 5 are reused for -gopen and i_left_h-gext.
    localparam int NOPS = 6;
    localparam logic [NOPS-1:0] OP_SUB = 6'b10_1111;

    sw_state_e state_q, state_d;
    logic      accept;
    logic      err_set;

    logic                 rst_q;
    logic [CW-1:0]        data_q;
    logic                 vld_q;
    logic signed [SW-1:0] right_h_q;
    logic signed [SW-1:0] right_e_q;
    logic signed [SW-1:0] high_q;
    logic [1:0]           tb_q;
    logic                 sat_q;
    logic                 err_q;
    logic signed [SW-1:0] f_up_q;
    logic signed [SW-1:0] diag_q;
    logic signed [SW-1:0] bnd_q;

    logic signed [SW-1:0] lh;
    logic signed [SW-1:0] le;
    logic signed [SW-1:0] s_val;
    logic signed [SW-1:0] e_d;
    logic signed [SW-1:0] f_d;
    logic signed [SW-1:0] h_d;
    logic signed [SW-1:0] high_d;
    logic signed [SW-1:0] floor_v;
    logic [1:0]           tb_d;

    logic signed [SW-1:0] op_a [NOPS];
    logic signed [SW-1:0] op_b [NOPS];
    logic signed [SW-1:0] op_y [NOPS];
    logic [NOPS-1:0]      op_sat;
    logic [NOPS-1:0]      score_sat;

    assign lh    = i_first ? bnd_q : i_left_h;
    assign le    = i_first ? bnd_q : i_left_e;
    assign s_val = (i_data == i_preload) ? i_match : i_mismatch;

    always_comb begin
        op_a[0] = lh;
        op_b[0] = $signed(i_gopen);
        op_a[1] = le;
        op_b[1] = $signed(i_gext);
        op_a[2] = i_rst ? '0 : right_h_q;
        op_b[2] = $signed(i_gopen);
        op_a[3] = f_up_q;
        op_b[3] = $signed(i_gext);
        op_a[4] = diag_q;
        op_b[4] = s_val;
        op_a[5] = i_rst ? i_left_h : bnd_q;
        op_b[5] = $signed(i_gext);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_op
            sw_sat_addsub #(.SW(SW)) u_op (
                .a_i   (op_a[gi]),
                .b_i   (op_b[gi]),
                .sub_i (OP_SUB[gi]),
                .y_o   (op_y[gi]),
                .sat_o (op_sat[gi])
            );
            // NEG stands for minus infinity, so pushing it further down is not an overflow.
            assign score_sat[gi] = op_sat[gi] & (op_a[gi] != NEG);
        end
    endgenerate

    // Max selection with traceback priority diag > up > left > local floor.
    always_comb begin
        e_d     = (op_y[0] >= op_y[1]) ? op_y[0] : op_y[1];
        f_d     = (op_y[2] >= op_y[3]) ? op_y[2] : op_y[3];
        floor_v = i_local ? '0 : NEG;
        h_d     = op_y[4];
        tb_d    = TB_DIAG;
        if (op_y[4] >= f_d && op_y[4] >= e_d && op_y[4] >= floor_v) begin
            h_d  = op_y[4];
            tb_d = TB_DIAG;
        end else if (f_d >= e_d && f_d >= floor_v) begin
            h_d  = f_d;
            tb_d = TB_UP;
        end else if (e_d >= floor_v) begin
            h_d  = e_d;
            tb_d = TB_LEFT;
        end else begin
            h_d  = floor_v;
            tb_d = TB_ZERO;
        end
        high_d = high_q;
        if (h_d > high_d) begin
            high_d = h_d;
        end
        if (i_high > high_d) begin
            high_d = i_high;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_vld) begin
                    accept  = 1'b1;
                    state_d = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (i_vld) begin
                    accept = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_set = i_vld;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= i_rst;
        if (i_rst) begin
            vld_q     <= 1'b0;
            data_q    <= '0;
            tb_q      <= TB_ZERO;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            f_up_q    <= NEG;
            right_e_q <= NEG;
            if (i_local) begin
                right_h_q <= '0;
                diag_q    <= '0;
                high_q    <= '0;
                bnd_q     <= '0;
            end else begin
                right_h_q <= i_first ? op_y[2] : op_y[5];
                diag_q    <= i_first ? '0 : i_left_h;
                high_q    <= NEG;
                bnd_q     <= op_y[2];
            end
        end else begin
            vld_q <= accept;
            if (accept) begin
                right_h_q <= h_d;
                right_e_q <= e_d;
                f_up_q    <= f_d;
                diag_q    <= lh;
                data_q    <= i_data;
                tb_q      <= tb_d;
                bnd_q     <= op_y[5];
                high_q    <= high_d;
                sat_q     <= sat_q | (|score_sat);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_rst     = rst_q;
    assign o_data    = data_q;
    assign o_vld     = vld_q;
    assign o_right_h = right_h_q;
    assign o_right_e = right_e_q;
    assign o_high    = high_q;
    assign o_tb      = tb_q;
    assign o_sat     = sat_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_sw_pe_gotoh.sv
// Directed bench for one Gotoh PE: local/global scoring, boundary, saturation and protocol.
module tb_sw_pe_gotoh;

    localparam int SW  = 12;
    localparam int CW  = 2;
    localparam int NEG = -2048;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_G = 2'd2;
    localparam logic [1:0] CH_T = 2'd3;

    logic                 clk;
    logic                 i_rst;
    logic                 i_local;
    logic                 i_first;
    logic [CW-1:0]        i_preload;
    logic signed [SW-1:0] i_match;
    logic signed [SW-1:0] i_mismatch;
    logic [SW-1:0]        i_gopen;
    logic [SW-1:0]        i_gext;
    logic [CW-1:0]        i_data;
    logic                 i_vld;
    logic signed [SW-1:0] i_left_h;
    logic signed [SW-1:0] i_left_e;
    logic signed [SW-1:0] i_high;
    logic                 o_rst;
    logic [CW-1:0]        o_data;
    logic                 o_vld;
    logic signed [SW-1:0] o_right_h;
    logic signed [SW-1:0] o_right_e;
    logic signed [SW-1:0] o_high;
    logic [1:0]           o_tb;
    logic                 o_sat;
    logic                 o_err;

    int n_checks = 0;
    int n_fail   = 0;

    sw_pe_gotoh #(.SW(SW), .CW(CW)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_local    (i_local),
        .i_first    (i_first),
        .i_preload  (i_preload),
        .i_match    (i_match),
        .i_mismatch (i_mismatch),
        .i_gopen    (i_gopen),
        .i_gext     (i_gext),
        .i_data     (i_data),
        .i_vld      (i_vld),
        .i_left_h   (i_left_h),
        .i_left_e   (i_left_e),
        .i_high     (i_high),
        .o_rst      (o_rst),
        .o_data     (o_data),
        .o_vld      (o_vld),
        .o_right_h  (o_right_h),
        .o_right_e  (o_right_e),
        .o_high     (o_high),
        .o_tb       (o_tb),
        .o_sat      (o_sat),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for several cycles; outputs are inspected before the release edge.
    task automatic do_reset(input logic loc, input logic first, input int exp_h, input int exp_high);
        i_rst   = 1'b1;
        i_vld   = 1'b0;
        i_local = loc;
        i_first = first;
        repeat (3) step();
        $display("reset local=%0d first=%0d: H=%0d E=%0d high=%0d tb=%0d",
                 loc, first, o_right_h, o_right_e, o_high, o_tb);
        chk("rst.o_rst", int'(o_rst), 1);
        chk("rst.vld", int'(o_vld), 0);
        chk("rst.tb", int'(o_tb), 0);
        chk("rst.data", int'(o_data), 0);
        chk("rst.sat", int'(o_sat), 0);
        chk("rst.err", int'(o_err), 0);
        chk("rst.e", int'(o_right_e), NEG);
        chk("rst.h", int'(o_right_h), exp_h);
        chk("rst.high", int'(o_high), exp_high);
        i_rst = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [1:0] d, input int exp_h,
                        input int exp_e, input int exp_tb, input int exp_high);
        i_data = d;
        i_vld  = 1'b1;
        step();
        $display("beat %s: data=%0d vld=%0d H=%0d E=%0d tb=%0d high=%0d sat=%0d",
                 tag, d, o_vld, o_right_h, o_right_e, o_tb, o_high, o_sat);
        chk({tag, ".vld"}, int'(o_vld), 1);
        chk({tag, ".h"}, int'(o_right_h), exp_h);
        chk({tag, ".e"}, int'(o_right_e), exp_e);
        chk({tag, ".tb"}, int'(o_tb), exp_tb);
        chk({tag, ".high"}, int'(o_high), exp_high);
        chk({tag, ".data"}, int'(o_data), int'(d));
    endtask

    task automatic idle(input string tag, input int exp_h);
        i_vld = 1'b0;
        step();
        $display("idle %s: vld=%0d H=%0d", tag, o_vld, o_right_h);
        chk({tag, ".vld"}, int'(o_vld), 0);
        chk({tag, ".hold"}, int'(o_right_h), exp_h);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_local    = 1'b1;
        i_first    = 1'b1;
        i_preload  = CH_A;
        i_match    = 12'sd5;
        i_mismatch = -12'sd4;
        i_gopen    = 12'd12;
        i_gext     = 12'd4;
        i_data     = CH_A;
        i_vld      = 1'b0;
        i_left_h   = '0;
        i_left_e   = '0;
        i_high     = '0;

        // Local match on the left edge: A,A against preload A.
        do_reset(1'b1, 1'b1, 0, 0);
        step();
        chk("rel.o_rst", int'(o_rst), 0);
        chk("rel.vld", int'(o_vld), 0);
        beat("lm1", CH_A, 5, -4, 1, 5);
        beat("lm2", CH_A, 5, -8, 1, 5);
        idle("lm_end", 5);

        // Local mismatch falls to the zero floor.
        do_reset(1'b1, 1'b1, 0, 0);
        beat("lx1", CH_G, 0, -4, 0, 0);

        // Global left-edge boundary: T,T against preload A.
        i_high = 12'(NEG);
        do_reset(1'b0, 1'b1, -12, NEG);
        beat("gb1", CH_T, -4, -16, 1, -4);
        beat("gb2", CH_T, -16, -20, 1, -4);
        chk("gb.sat", int'(o_sat), 0);

        // Global reset of an inner PE: i_left_h - gext clips at the negative rail.
        i_left_h = -12'sd2046;
        do_reset(1'b0, 1'b0, NEG, NEG);
        i_left_h = -12'sd20;
        do_reset(1'b0, 1'b0, -24, NEG);

        // Saturation: inner PE fed H=2047 from the left with match=2047.
        i_high   = '0;
        i_match  = 12'sd2047;
        i_left_h = 12'sd2047;
        i_left_e = 12'(NEG);
        do_reset(1'b1, 1'b0, 0, 0);
        beat("st1", CH_A, 2047, 2035, 1, 2047);
        chk("st1.sat", int'(o_sat), 0);
        beat("st2", CH_A, 2047, 2035, 1, 2047);
        chk("st2.sat", int'(o_sat), 1);

        // Protocol: a beat after the stream has ended is refused and flagged.
        i_match  = 12'sd5;
        i_left_h = '0;
        i_left_e = '0;
        do_reset(1'b1, 1'b1, 0, 0);
        beat("pr1", CH_A, 5, -4, 1, 5);
        idle("pr_gap", 5);
        chk("pr_gap.err", int'(o_err), 0);
        i_data = CH_G;
        i_vld  = 1'b1;
        step();
        $display("late beat: vld=%0d err=%0d H=%0d data=%0d", o_vld, o_err, o_right_h, o_data);
        chk("pr_late.vld", int'(o_vld), 0);
        chk("pr_late.err", int'(o_err), 1);
        chk("pr_late.hold", int'(o_right_h), 5);
        chk("pr_late.data", int'(o_data), int'(CH_A));
        i_vld = 1'b0;
        i_rst = 1'b1;
        step();
        $display("reset after error: err=%0d", o_err);
        chk("pr_rst.err", int'(o_err), 0);
        i_rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_pe_gotoh.md
SW_PE_GOTOH -- requirements
Module: sw_pe_gotoh

Interface
REQ-001 SHALL have parameter SW, default 12: signed two's-complement score width.
REQ-002 SHALL have parameter CW, default 2: character width (2 for DNA, 5 for protein).
REQ-003 SHALL have ports clk, in, 1, clock; i_rst, in, 1, reset, synchronous, active-high; reset i_rst, synchronous, active-high; clock clk.
REQ-004 SHALL have ports i_local (in, 1, 1 = local, 0 = global), i_first (in, 1, left edge of array) and i_preload (in, CW, query character held by this PE).
REQ-005 SHALL have ports i_match and i_mismatch (in, SW, signed substitution scores), and i_gopen and i_gext (in, SW, unsigned penalties, each below 2^(SW-1)).
REQ-006 SHALL have ports i_data (in, CW, database character), i_vld (in, 1), i_left_h and i_left_e (in, SW, neighbour H/E) and i_high (in, SW, neighbour best score).
REQ-007 SHALL have ports o_rst (out, 1), o_data (out, CW), o_vld (out, 1), o_right_h and o_right_e (out, SW), o_high (out, SW), o_tb (out, 2, traceback) and o_sat and o_err (out, 1, sticky flags).

Function
REQ-008 SHALL take all arithmetic as saturating to [NEG = -2^(SW-1), 2^(SW-1)-1], and SHALL set o_sat sticky when any result clips.
REQ-009 SHALL define s = (i_data == i_preload) ? i_match : i_mismatch.
REQ-010 SHALL define the left operands as follows: when i_first, Lh = Le = bnd; otherwise Lh = i_left_h and Le = i_left_e.
REQ-011 SHALL compute E = max(Lh - gopen, Le - gext), F = max(o_right_h - gopen, f_up - gext), D = diag + s and H = max(D, F, E, local ? 0 : NEG).
REQ-012 SHALL take the o_tb priority on ties as diag > up > left: 01 = D, 10 = F, 11 = E, and 00 = local floor (H = 0 with D, E and F all below 0).
REQ-013 SHALL, on each accepted beat (i_vld in IDLE or SCORE), register all of the following one cycle later: o_right_h <= H, o_right_e <= E, f_up <= F, diag <= Lh, o_data <= i_data, o_tb, o_vld <= 1, bnd <= bnd - gext, and o_high <= max(o_high, H, i_high).
REQ-014 SHALL set latency to 1 cycle from input to output per PE.
REQ-015 SHALL deassert o_vld on any cycle with no accepted beat, holding all other outputs.
REQ-016 SHALL use FSM states IDLE, SCORE and DONE: IDLE goes to SCORE on i_vld; SCORE goes to DONE on !i_vld; DONE is left only via i_rst.
REQ-017 SHALL ignore i_vld in DONE (no output update, o_vld = 0) and SHALL set o_err sticky.
REQ-018 SHALL register o_rst <= i_rst every cycle.

Reset
REQ-019 SHALL apply i_rst regardless of state, including mid-SCORE, and SHALL force IDLE.
REQ-020 SHALL, on reset, set o_vld = 0, o_data = 0, o_tb = 00, o_sat = 0, o_err = 0, f_up = NEG and o_right_e = NEG.
REQ-021 SHALL, on reset in local mode, set o_right_h = 0, diag = 0 and o_high = 0.
REQ-022 SHALL, on reset in global mode, set o_right_h = i_first ? -gopen : i_left_h - gext, diag = i_first ? 0 : i_left_h, bnd = -gopen and o_high = NEG.
REQ-023 SHALL, in global mode, settle the boundary values only if i_rst is held for at least (number of PEs + 1) cycles; this is a system requirement.

Structure
REQ-024 SHALL place the following in shared package sw_pkg: SW/CW defaults, the TB_ZERO, TB_DIAG, TB_UP and TB_LEFT codes, NEG/POS constants per width, and the state enum.
REQ-025 SHALL implement saturating add/sub in sub-module sw_sat_addsub (parameter SW, sat-flag output), instantiated per arithmetic operator.

Verification (SW=12, CW=2, match=5, mismatch=-4, gopen=12, gext=4)
REQ-026 SHALL cover local reset: after reset, o_right_h = 0, o_high = 0, o_vld = 0 and o_tb = 00.
REQ-027 SHALL cover a local match with i_first and preload A: stream A,A gives H 5 then 5, o_tb 01 then 01, o_high 5 and o_vld high for 2 cycles.
REQ-028 SHALL cover a local mismatch: preload A, stream G gives H = 0, o_tb = 00 and o_high = 0.
REQ-029 SHALL cover a global boundary with i_first and preload A: stream T,T gives H -4 (tb 01) then -16 (D = F = -16, tb 01).
REQ-030 SHALL cover saturation: i_match = 2047 with stream A,A and preload A gives H = 2047 and o_sat = 1 on row 2.
REQ-031 SHALL cover the protocol check: vld 1,0,1 without reset gives the second beat ignored, o_err = 1 and o_vld = 0; a following i_rst clears o_err.
